// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and slice width.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// nibble_cla: combinational 4-bit carry-lookahead adder slice.
module nibble_cla
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W-1:0] g_s;
  logic [NIBBLE_W-1:0] p_s;
  logic [NIBBLE_W:0]   c_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Every carry is a flat generate/propagate expression of the slice carry-in
  assign c_s[0] = c;
  assign c_s[1] = g_s[0] | (p_s[0] & c);
  assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c);
  assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & c);
  assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c);

  assign s  = p_s ^ c_s[NIBBLE_W-1:0];
  assign co = c_s[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a shared CLA slice.
// Optional subtract mode and signed-overflow output: define SERIAL_ADDER_SUB_EN.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
  output logic             V,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_e              state_r;
  state_e              state_s;
  logic [IDX_W-1:0]    idx_r;
  logic                carry_r;
  logic [WIDTH-1:0]    a_r;
  logic [WIDTH-1:0]    b_r;
  logic [WIDTH-1:0]    s_r;
  logic                cout_r;
  logic                out_valid_r;
  logic                accept_s;
  logic                last_s;
  logic                sub_s;
  logic [NIBBLE_W-1:0] a_nib_s;
  logic [NIBBLE_W-1:0] b_nib_s;
  logic [NIBBLE_W-1:0] sum_nib_s;
  logic                co_nib_s;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_s = Sub;
`else
  assign sub_s = 1'b0;
`endif

  assign a_nib_s = a_r[idx_r*NIBBLE_W +: NIBBLE_W];
  assign b_nib_s = b_r[idx_r*NIBBLE_W +: NIBBLE_W];

  nibble_cla u_cla (
    .a  (a_nib_s),
    .b  (b_nib_s),
    .c  (carry_r),
    .s  (sum_nib_s),
    .co (co_nib_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode plus accept/last-nibble strobes
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          accept_s = 1'b1;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (idx_r == LAST_IDX) begin
          last_s  = 1'b1;
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Operand capture, nibble sequencing and result assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r       <= '0;
      carry_r     <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      s_r         <= '0;
      cout_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      // Subtraction is A + ~B + 1, so the inversion and carry-in happen here
      a_r     <= A;
      b_r     <= sub_s ? ~B : B;
      carry_r <= sub_s ? 1'b1 : Cin;
      idx_r   <= '0;
    end else if (state_r == RUN) begin
      s_r[idx_r*NIBBLE_W +: NIBBLE_W] <= sum_nib_s;
      carry_r <= co_nib_s;
      idx_r   <= idx_r + IDX_ONE;
      if (last_s) begin
        cout_r      <= co_nib_s;
        out_valid_r <= 1'b1;
      end
    end else if ((state_r == DONE) && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

`ifdef SERIAL_ADDER_SUB_EN
  logic v_r;

  // Signed overflow: carry into the MSB differs from the carry out of it
  always_ff @(posedge clk) begin
    if (rst) begin
      v_r <= 1'b0;
    end else if (last_s) begin
      v_r <= (sum_nib_s[NIBBLE_W-1] ^ a_nib_s[NIBBLE_W-1] ^ b_nib_s[NIBBLE_W-1]) ^ co_nib_s;
    end
  end

  assign V = v_r;
`endif

  assign in_ready  = (state_r == IDLE) && !rst;
  assign busy      = (state_r == RUN) || (state_r == DONE);
  assign out_valid = out_valid_r;
  assign S         = s_r;
  assign Cout      = cout_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized self-checking bench: 16-bit and 8-bit instances against an arithmetic model.
`timescale 1ns/1ps
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv16, ir16, ov16, ordy16, cin16, co16, busy16, sub16;
  logic [15:0] a16, b16, s16;
  logic        iv8, ir8, ov8, ordy8, cin8, co8, busy8, sub8;
  logic [7:0]  a8, b8, s8;
`ifdef SERIAL_ADDER_SUB_EN
  logic        v16, v8;
`endif

  int total = 0;
  int bad   = 0;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
    .A(a16), .B(b16), .Cin(cin16),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub(sub16), .V(v16),
`endif
    .out_valid(ov16), .out_ready(ordy16), .S(s16), .Cout(co16), .busy(busy16)
  );

  nibble_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .A(a8), .B(b8), .Cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub(sub8), .V(v8),
`endif
    .out_valid(ov8), .out_ready(ordy8), .S(s8), .Cout(co8), .busy(busy8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic; V from the signed-range test
  task automatic model(input int w, input longint a, input longint b, input bit c, input bit sb,
                       output longint s, output bit co, output bit v);
    longint m, sa, sbv, full;
    m = longint'(1) << w;
    if (sb) begin
      s  = (a - b + m) % m;
      co = (a >= b);
    end else begin
      full = a + b + longint'(c);
      s    = full % m;
      co   = (full >= m);
    end
    sa   = (a >= m / 2) ? a - m : a;
    sbv  = (b >= m / 2) ? b - m : b;
    full = sb ? (sa - sbv) : (sa + sbv + longint'(c));
    v    = (full >= m / 2) || (full < -(m / 2));
  endtask

  task automatic txn16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic sb,
                       input int hold, input string tag);
    longint es; bit ec, ev; int lat;
    model(16, longint'(a), longint'(b), c, sb, es, ec, ev);
    @(negedge clk);
    check_eq({tag, ":in_ready_idle"}, 32'(ir16), 32'd1);
    iv16 = 1'b1; a16 = a; b16 = b; cin16 = c; sub16 = sb;
    @(posedge clk);
    lat = 0;
    forever begin
      @(negedge clk);
      if (ov16 === 1'b1 || lat >= 40) break;
      check_eq({tag, ":busy_run"}, 32'(busy16), 32'd1);
      check_eq({tag, ":in_ready_run"}, 32'(ir16), 32'd0);
      iv16 = 1'($urandom_range(0, 1)); a16 = 16'($urandom); b16 = 16'($urandom);
      cin16 = 1'($urandom); sub16 = 1'($urandom); ordy16 = 1'($urandom_range(0, 1));
      @(posedge clk);
      lat++;
    end
    ordy16 = 1'b0;
    check_eq({tag, ":latency"}, 32'(lat), 32'd4);
    check_eq({tag, ":S"}, 32'(s16), 32'(es));
    check_eq({tag, ":Cout"}, 32'(co16), 32'(ec));
`ifdef SERIAL_ADDER_SUB_EN
    check_eq({tag, ":V"}, 32'(v16), 32'(ev));
`endif
    for (int i = 0; i < hold; i++) begin
      iv16 = 1'($urandom_range(0, 1)); a16 = 16'($urandom); b16 = 16'($urandom);
      @(negedge clk);
      check_eq({tag, ":hold_valid"}, 32'(ov16), 32'd1);
      check_eq({tag, ":hold_S"}, 32'(s16), 32'(es));
      check_eq({tag, ":hold_Cout"}, 32'(co16), 32'(ec));
      check_eq({tag, ":hold_in_ready"}, 32'(ir16), 32'd0);
      check_eq({tag, ":hold_busy"}, 32'(busy16), 32'd1);
    end
    iv16 = 1'b0; ordy16 = 1'b1;
    @(negedge clk);
    ordy16 = 1'b0;
    check_eq({tag, ":release_valid"}, 32'(ov16), 32'd0);
    check_eq({tag, ":release_in_ready"}, 32'(ir16), 32'd1);
    check_eq({tag, ":release_busy"}, 32'(busy16), 32'd0);
  endtask

  task automatic txn8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sb,
                      input int hold);
    longint es; bit ec, ev; int lat;
    model(8, longint'(a), longint'(b), c, sb, es, ec, ev);
    @(negedge clk);
    check_eq("w8:in_ready_idle", 32'(ir8), 32'd1);
    iv8 = 1'b1; a8 = a; b8 = b; cin8 = c; sub8 = sb;
    @(posedge clk);
    lat = 0;
    forever begin
      @(negedge clk);
      if (ov8 === 1'b1 || lat >= 40) break;
      check_eq("w8:in_ready_run", 32'(ir8), 32'd0);
      iv8 = 1'($urandom_range(0, 1)); a8 = 8'($urandom); b8 = 8'($urandom);
      cin8 = 1'($urandom); sub8 = 1'($urandom); ordy8 = 1'($urandom_range(0, 1));
      @(posedge clk);
      lat++;
    end
    ordy8 = 1'b0;
    check_eq("w8:latency", 32'(lat), 32'd2);
    check_eq("w8:S", 32'(s8), 32'(es));
    check_eq("w8:Cout", 32'(co8), 32'(ec));
`ifdef SERIAL_ADDER_SUB_EN
    check_eq("w8:V", 32'(v8), 32'(ev));
`endif
    for (int i = 0; i < hold; i++) begin
      iv8 = 1'($urandom_range(0, 1)); a8 = 8'($urandom);
      @(negedge clk);
      check_eq("w8:hold_valid", 32'(ov8), 32'd1);
      check_eq("w8:hold_S", 32'(s8), 32'(es));
    end
    iv8 = 1'b0; ordy8 = 1'b1;
    @(negedge clk);
    ordy8 = 1'b0;
    check_eq("w8:release_valid", 32'(ov8), 32'd0);
    check_eq("w8:release_in_ready", 32'(ir8), 32'd1);
  endtask

  task automatic soak16(input int n);
    for (int k = 0; k < n; k++) begin
      logic [15:0] a, b;
      logic sb;
      sb = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sb = 1'($urandom);
`endif
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      b = 16'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      txn16(a, b, 1'($urandom), sb, $urandom_range(0, 3), "soak16");
    end
  endtask

  task automatic soak8(input int n);
    for (int k = 0; k < n; k++) begin
      logic [7:0] a, b;
      logic sb;
      sb = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sb = 1'($urandom);
`endif
      a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      b = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      txn8(a, b, 1'($urandom), sb, $urandom_range(0, 3));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    iv16 = 1'b0; ordy16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
    iv8  = 1'b0; ordy8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0; sub8  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset:in_ready", 32'(ir16), 32'd0);
    check_eq("reset:out_valid", 32'(ov16), 32'd0);
    check_eq("reset:S", 32'(s16), 32'd0);
    check_eq("reset:Cout", 32'(co16), 32'd0);
    check_eq("reset:busy", 32'(busy16), 32'd0);
    check_eq("reset:w8_out_valid", 32'(ov8), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("reset:in_ready_release", 32'(ir16), 32'd1);

    txn16(16'h1234, 16'h4321, 1'b0, 1'b0, 0, "basic");
    txn16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, "ripple");
    txn16(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, "cin_ripple");
    txn16(16'h00F0, 16'h0F10, 1'b0, 1'b0, 5, "backpressure");

    // Reset lands on the second RUN cycle of an add
    @(negedge clk);
    iv16 = 1'b1; a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b0; sub16 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst:out_valid", 32'(ov16), 32'd0);
    check_eq("midrst:S", 32'(s16), 32'd0);
    check_eq("midrst:Cout", 32'(co16), 32'd0);
    check_eq("midrst:busy", 32'(busy16), 32'd0);
    check_eq("midrst:in_ready_in_rst", 32'(ir16), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("midrst:in_ready_after", 32'(ir16), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("midrst:no_result", 32'(ov16), 32'd0);
    end
    txn16(16'h0001, 16'h0001, 1'b0, 1'b0, 0, "post_reset");

`ifdef SERIAL_ADDER_SUB_EN
    txn16(16'h0005, 16'h0007, 1'b0, 1'b1, 1, "sub_neg");
    txn16(16'h8000, 16'h0001, 1'b0, 1'b1, 0, "sub_ovf");
`endif

    fork
      soak16(1000);
      soak8(1000);
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle wide adder that accepts WIDTH-bit operands over a valid/ready handshake. It feeds them one nibble per cycle into a 4-bit carry-lookahead slice and chains the carry through a register. It consumes each nibble's sum and carry-out and assembles the full result plus final carry. It sits between operand-producing logic and any result consumer where area matters more than latency.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
NIBBLES, WIDTH/4, derived localparam; number of slice iterations.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands on A/B/Cin are valid.
in_ready  output  1  block can accept operands.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
Cin  input  1  carry-in to bit 0.
out_valid  output  1  S/Cout hold a completed result.
out_ready  input  1  consumer accepts the result.
S  output  WIDTH  sum, registered.
Cout  output  1  carry out of bit WIDTH-1, registered.
busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; sampled only on the rising edge of clk.
- Reset: state=IDLE, nibble index=0, carry reg=0, operand regs=0.
  - Outputs during/after reset: S=0, Cout=0, out_valid=0, busy=0.
  - in_ready = (state==IDLE) && !rst, so it is 0 while rst is high and 1 on the first cycle after release.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture A, B, Cin into internal regs; idx<=0; carry<=Cin; go RUN.
  - in_valid while not in IDLE is ignored. No queuing.
- RUN (one nibble per cycle):
  - Slice inputs: a=A_reg[4*idx+:4], b=B_reg[4*idx+:4], c=carry.
  - S[4*idx+:4] <= slice sum; carry <= slice cout; idx <= idx+1.
  - When idx==NIBBLES-1: Cout <= slice cout, out_valid <= 1, go DONE.
  - in_ready=0.
- Latency: out_valid rises exactly NIBBLES clock edges after the acceptance edge (4 for WIDTH=16). Throughput is one add per NIBBLES+2 cycles at best.
- DONE:
  - S, Cout, out_valid held stable.
  - On out_ready: out_valid<=0, go IDLE.
  - in_ready stays 0 in DONE. There is no same-cycle release/accept bypass.
- S is only partially updated during RUN; it is valid only while out_valid=1.
- The carry is purely modular: S = (A+B+Cin) mod 2^WIDTH and Cout = bit WIDTH of the true sum.
- WIDTH=4 degenerates to a single RUN cycle; it must still pass through RUN and DONE.
- rst asserted in any state, including mid-RUN: the in-flight operation is discarded, reset values apply at the next edge, and no out_valid is emitted for it.
- out_ready asserted while not in DONE has no effect.

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- When defined:
  - Adds input Sub (1 bit), captured with the operands.
  - When Sub=1, B is inverted on capture, Cin is ignored and the carry reg is loaded with 1. This computes A-B, with Cout=1 meaning no borrow.
  - Adds output V (1 bit, registered): signed overflow = carry into MSB XOR carry out of MSB, taken in the last RUN cycle. V resets to 0 and is held in DONE.
- When undefined: no Sub or V ports. Behaviour is add-only as above.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a NIBBLE_W=4 constant.
- One sub-module, nibble_cla: a combinational 4-bit carry-lookahead adder with ports a[3:0], b[3:0], c, s[3:0], co. It is instantiated once; all sequencing stays in the top module.

Test Plan:
- A=0x1234, B=0x4321, Cin=0 -> S=0x5555, Cout=0; out_valid rises 4 edges after acceptance; busy high throughout.
- A=0xFFFF, B=0x0001, Cin=0 -> S=0x0000, Cout=1 (carry ripples through all nibbles). Repeat with A=0xFFFF, B=0x0000, Cin=1 -> S=0x0000, Cout=1.
- Backpressure: A=0x00F0, B=0x0F10; hold out_ready=0 for 5 cycles -> S=0x1000, Cout=0 stable, in_ready=0 throughout. Pulse out_ready -> IDLE, in_ready=1 next cycle. A new in_valid presented during DONE is not accepted.
- rst pulse on the 2nd RUN cycle of A=0xAAAA, B=0x5555 -> the next edge shows S=0, Cout=0, out_valid=0, in_ready=1 after rst drops. A follow-up add of 0x0001+0x0001 returns 0x0002.
- SERIAL_ADDER_SUB_EN: Sub=1, A=0x0005, B=0x0007 -> S=0xFFFE, Cout=0, V=0. Then A=0x8000, B=0x0001 -> S=0x7FFF, Cout=1, V=1.
- Random soak, WIDTH=8 and 16, 1000 transactions with random in_valid/out_ready gaps -> every result matches the reference model, and no accept occurs outside IDLE.
